// File: rtl/transpose_scheduler.sv
// Round-robin scheduler that time-shares one transpose unit among NUM_REQ requesters,
// tracks the in-flight result through the unit's fixed latency and hands it to a consumer.
module transpose_scheduler #(
    parameter int  NUM_REQ = 4,
    parameter int  LAT     = 1,
    parameter int  OPS_W   = 16,
    localparam int SEL_W   = $clog2(NUM_REQ + 1),
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [NUM_REQ-1:0] req_mode,
    output logic [NUM_REQ-1:0] req_ready,
    output logic               tp_ctrl,
    output logic [SEL_W-1:0]   tp_sel,
    output logic               rsp_valid,
    output logic [ID_W-1:0]    rsp_id,
    output logic               rsp_mode,
    input  logic               rsp_ready,
    output logic [OPS_W-1:0]   ops_done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RSP
    } state_t;

    localparam logic [3:0]       CNT_LOAD = 4'(LAT - 1);
    localparam logic [SEL_W-1:0] SEL_HOLD = SEL_W'(NUM_REQ);
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);

    state_t           state_q;
    logic [ID_W-1:0]  rr_ptr_q;
    logic [ID_W-1:0]  rr_ptr_d;
    logic [3:0]       cnt_q;
    logic [ID_W-1:0]  rsp_id_q;
    logic             rsp_mode_q;
    logic [OPS_W-1:0] ops_done_q;
    logic [OPS_W-1:0] ops_done_d;

    logic             grant_ok;
    logic             found;
    logic             grant;
    logic [ID_W-1:0]  win_idx;
    logic [ID_W-1:0]  cand;

    // Round-robin search starting at rr_ptr_q; the first valid requester wins.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no latch is inferred.
        found   = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    // A new operation may enter only when the unit is empty or its result leaves this cycle.
    assign grant_ok = !rst && ((state_q == ST_IDLE) || ((state_q == ST_RSP) && rsp_ready));
    assign grant    = grant_ok && found;

    assign req_ready = grant ? (NUM_REQ'(1) << win_idx) : '0;
    assign tp_sel    = grant ? SEL_W'(win_idx) : SEL_HOLD;
    assign tp_ctrl   = grant && req_mode[win_idx];

    assign rsp_valid = !rst && (state_q == ST_RSP);
    assign rsp_id    = rsp_id_q;
    assign rsp_mode  = rsp_mode_q;
    assign ops_done  = ops_done_q;

    assign rr_ptr_d   = (win_idx == LAST_ID) ? '0 : win_idx + 1'b1;
    assign ops_done_d = (ops_done_q == '1) ? ops_done_q : ops_done_q + 1'b1;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every read sees pre-edge values.
        if (rst) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            cnt_q      <= '0;
            rsp_id_q   <= '0;
            rsp_mode_q <= 1'b0;
            ops_done_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_WAIT: begin
                    if (cnt_q <= 4'd1) begin
                        state_q <= ST_RSP;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase

            // A grant overrides the RSP->IDLE move above, giving back-to-back issue.
            if (grant) begin
                state_q    <= (LAT == 1) ? ST_RSP : ST_WAIT;
                cnt_q      <= CNT_LOAD;
                rr_ptr_q   <= rr_ptr_d;
                rsp_id_q   <= win_idx;
                rsp_mode_q <= req_mode[win_idx];
            end

            if (rsp_valid && rsp_ready) ops_done_q <= ops_done_d;
        end
    end

endmodule
